// File: rtl/sr_cmd_sequencer_if.sv
// Request/strobe bundle between the command source and sr_cmd_sequencer.
// The master drives the raw requests and the slave (the sequencer) returns the SR strobes.
interface sr_cmd_sequencer_if;
  logic set_req;
  logic clr_req;
  logic s;
  logic r;
  logic busy;
  logic conflict;

  modport master (
    output set_req,
    output clr_req,
    input  s,
    input  r,
    input  busy,
    input  conflict
  );

  modport slave (
    input  set_req,
    input  clr_req,
    output s,
    output r,
    output busy,
    output conflict
  );
endinterface

// File: rtl/sr_cmd_sequencer.sv
// Debounces raw set/clear request levels and turns each qualified rising edge into a
// single-cycle s or r strobe, with mutual exclusion and a minimum gap between strobes.
module sr_cmd_sequencer #(
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  sr_cmd_sequencer_if.slave cmd
);

  localparam int            DW        = $clog2(DB_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES);
  localparam int            HW        = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    CLR_P = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [HW-1:0]   r_hold_cnt;
  logic [HW-1:0]   w_hold_cnt_next;
  logic            r_conflict;
  logic            w_conflict_next;

  // Index 0 is the set path, index 1 is the clear path.
  logic [1:0]      w_raw;
  logic [1:0]      w_pend;
  logic [1:0]      w_consume;

  assign w_raw = {cmd.clr_req, cmd.set_req};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_db
      logic          r_f;
      logic [DW-1:0] r_cnt;
      logic          r_pend;
      logic [DW-1:0] w_cnt_inc;
      logic          w_rise;

      assign w_cnt_inc = r_cnt + DW'(1);
      assign w_rise    = (w_raw[gi] != r_f) && (w_cnt_inc == DB_LAST) && !r_f;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_f    <= 1'b0;
          r_cnt  <= '0;
          r_pend <= 1'b0;
        end else begin
          if (w_raw[gi] == r_f) begin
            r_cnt <= '0;
          end else if (w_cnt_inc == DB_LAST) begin
            r_f   <= ~r_f;
            r_cnt <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
          // A rise landing while the flag is still held is dropped, so consume wins.
          if (w_consume[gi]) begin
            r_pend <= 1'b0;
          end else if (w_rise) begin
            r_pend <= 1'b1;
          end
        end
      end

      assign w_pend[gi] = r_pend;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_conflict <= w_conflict_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    w_conflict_next = 1'b0;
    w_consume       = 2'b00;
    case (r_state)
      IDLE: begin
        if (&w_pend) begin
          w_conflict_next = 1'b1;
          w_consume       = 2'b11;
        end else if (w_pend[0]) begin
          w_state_next = SET_P;
          w_consume    = 2'b01;
        end else if (w_pend[1]) begin
          w_state_next = CLR_P;
          w_consume    = 2'b10;
        end
      end
      SET_P, CLR_P: begin
        w_state_next    = HOLD;
        w_hold_cnt_next = '0;
      end
      HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_next = IDLE;
        end else begin
          w_hold_cnt_next = r_hold_cnt + HW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs decode only registered state, so nothing from the request pins reaches them combinationally.
  assign cmd.s        = (r_state == SET_P);
  assign cmd.r        = (r_state == CLR_P);
  assign cmd.busy     = (r_state != IDLE);
  assign cmd.conflict = r_conflict;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer: expected strobe/conflict events are queued when
// requests are driven and matched against what the DUT emits, cycle for cycle.
module tb_sr_cmd_sequencer;
  localparam int DB   = 4;
  localparam int HOLD = 2;
  localparam int K_S  = 1;
  localparam int K_R  = 2;
  localparam int K_C  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_cmd_sequencer_if bus ();

  sr_cmd_sequencer #(
    .DB_CYCLES  (DB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] ev(input int kind, input int c);
    return 32'(kind * 1000000 + c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s"},        32'(bus.s),        32'd0);
    check({tag, "_r"},        32'(bus.r),        32'd0);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_conflict"}, 32'(bus.conflict), 32'd0);
  endtask

  // Event monitor: every s/r/conflict pulse must match the next queued expectation.
  always @(negedge clk) begin
    int kind;
    check("s_and_r", 32'(bus.s & bus.r), 32'd0);
    if (bus.s || bus.r || bus.conflict) begin
      kind = bus.s ? K_S : (bus.r ? K_R : K_C);
      if (exp_q.size() == 0) check("unexpected_event", ev(kind, cyc), 32'd0);
      else                   check("event", ev(kind, cyc), exp_q.pop_front());
      $display("event kind=%0d cycle=%0d", kind, cyc);
    end
  end

  initial begin
    int c0;
    int c1;
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;

    // Reset state
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // Single set request held: one strobe, busy for 1+HOLD cycles
    c0 = cyc;
    bus.set_req = 1'b1;
    exp_q.push_back(ev(K_S, c0 + DB + 1));
    tick(DB + 1);
    check("set_strobe", 32'(bus.s), 32'd1);
    check("set_busy0",  32'(bus.busy), 32'd1);
    tick(1);
    check("set_s_off",  32'(bus.s), 32'd0);
    check("set_busy1",  32'(bus.busy), 32'd1);
    tick(1);
    check("set_busy2",  32'(bus.busy), 32'd1);
    tick(1);
    check("set_busy3",  32'(bus.busy), 32'd0);
    tick(10);
    bus.set_req = 1'b0;
    tick(8);

    // Glitchy clear: 3-cycle pulses never qualify
    for (int i = 0; i < 5; i++) begin
      bus.clr_req = 1'b1;
      tick(3);
      check("glitch_busy_hi", 32'(bus.busy), 32'd0);
      bus.clr_req = 1'b0;
      tick(3);
      check("glitch_busy_lo", 32'(bus.busy), 32'd0);
    end
    tick(4);

    // Simultaneous set and clear: conflict, no strobe
    c0 = cyc;
    bus.set_req = 1'b1;
    bus.clr_req = 1'b1;
    exp_q.push_back(ev(K_C, c0 + DB + 1));
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("conflict_busy", 32'(bus.busy), 32'd0);
    end
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    tick(8);

    // Clear arrives during HOLD: r strobe HOLD+2 cycles after s
    c0 = cyc;
    bus.set_req = 1'b1;
    exp_q.push_back(ev(K_S, c0 + DB + 1));
    tick(2);
    bus.clr_req = 1'b1;
    exp_q.push_back(ev(K_R, c0 + DB + 1 + HOLD + 2));
    tick(12);
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    tick(8);

    // Reset during HOLD with set still held: fresh strobe after release
    c0 = cyc;
    bus.set_req = 1'b1;
    exp_q.push_back(ev(K_S, c0 + DB + 1));
    tick(DB + 2);
    check("hold_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_in_hold");
    tick(1);
    rst = 1'b0;
    c1 = cyc;
    exp_q.push_back(ev(K_S, c1 + DB + 1));
    tick(DB + 1);
    check("post_rst_strobe", 32'(bus.s), 32'd1);
    tick(3);
    bus.set_req = 1'b0;
    tick(8);

    // Asynchronous reset in the middle of a strobe cycle
    c0 = cyc;
    bus.set_req = 1'b1;
    exp_q.push_back(ev(K_S, c0 + DB + 1));
    tick(DB + 1);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_in_strobe");
    tick(1);
    rst = 1'b0;
    c1 = cyc;
    exp_q.push_back(ev(K_S, c1 + DB + 1));
    tick(8);
    bus.set_req = 1'b0;
    tick(10);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sr_cmd_sequencer.md
# sr_cmd_sequencer

Upstream command stage for the SR flip-flop. It takes two raw, possibly bouncy request levels (`set_req`, `clr_req`), debounces each one, and converts each qualified rising edge into a single-cycle `s` or `r` strobe. It guarantees `s` and `r` are never asserted together and enforces a minimum gap between strobes. Its `s`/`r` outputs connect directly to the SR flip-flop's `s`/`r` inputs on the same `clk`/`rst`.

## Interface
- `DB_CYCLES`, default 4: consecutive samples a request must hold a new level before the filtered level changes. Legal range ≥ 2.
- `HOLD_CYCLES`, default 2: idle gap after each strobe before the next may issue. Legal range ≥ 1.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state immediately.
- `set_req`  in  1  raw set request level, synchronous to `clk`.
- `clr_req`  in  1  raw clear request level, synchronous to `clk`.
- `s`  out  1  registered set strobe, one cycle wide.
- `r`  out  1  registered reset strobe, one cycle wide.
- `busy`  out  1  registered; high in states `SET_P`, `CLR_P` and `HOLD`.
- `conflict`  out  1  registered one-cycle flag: simultaneous pending set and clear were discarded.

## Operation
- **Debounce, per input.**
  - Keep a filtered level `f` and a counter of width `$clog2(DB_CYCLES)+1`.
  - Each edge the raw input differs from `f`, the counter increments. On the edge where it reaches `DB_CYCLES`, `f` toggles and the counter clears.
  - Any edge where raw equals `f` clears the counter.
- **Pending flags.** A 0→1 change of `f` sets a one-deep pending flag (`set_pend` / `clr_pend`) on the same edge. A second rising edge while the flag is already set is dropped. Falling changes of `f` produce nothing.
- **FSM states and transitions:**
  - `IDLE`:
    - `set_pend` and `clr_pend` both set → `conflict`=1 for one cycle, clear both flags, stay in `IDLE`.
    - `set_pend` only → `SET_P`, clear `set_pend`.
    - `clr_pend` only → `CLR_P`, clear `clr_pend`.
  - `SET_P`: `s`=1 for exactly this cycle → `HOLD`.
  - `CLR_P`: `r`=1 for exactly this cycle → `HOLD`.
  - `HOLD`: wait `HOLD_CYCLES` cycles using a counter that is cleared on entry → `IDLE`.
- **Pending during busy.** Flags set during `SET_P`/`CLR_P`/`HOLD` are kept and serviced on the first `IDLE` evaluation.
- **Invariant.** `s & r` is never 1. Outputs are decoded from the registered state, with no combinational path from inputs to outputs.
- **Reset (any time, including mid-strobe or mid-HOLD):**
  - State → `IDLE`; `s`=`r`=`busy`=`conflict`=0.
  - Both `f`=0, both counters 0, both pending flags 0.
- **Request held through reset.** Because `f` resets to 0, a request still high when `rst` deasserts is treated as a new rising edge after `DB_CYCLES` samples.

## Timing
- **Rise to strobe.** Raw high sampled on edges E1..EN (N=`DB_CYCLES`):
  - `f`=1 and pend=1 after EN.
  - FSM leaves `IDLE` at EN+1, so `s`/`r` is high during the cycle after EN+1.
  - Latency from first sampling edge to strobe: N+1 edges.
- **Busy window.** `busy` is high for 1 + `HOLD_CYCLES` cycles starting with the strobe cycle.
- **Strobe spacing.** Minimum spacing between consecutive strobe rising edges is `HOLD_CYCLES` + 2 cycles.
- **Conflict.** `conflict` is asserted the cycle after the `IDLE` evaluation, lasts 1 cycle, and produces no strobe.
- **Glitch rejection.** A raw pulse shorter than N consecutive samples never changes `f`.

## Test plan
All scenarios use `DB_CYCLES`=4, `HOLD_CYCLES`=2, clock period 10 ns.
1. Assert `rst`=1 asynchronously mid-cycle → `s`=`r`=`busy`=`conflict`=0 immediately, before the next posedge.
2. `set_req` 0→1, held, first sampled at edge E1 → `s`=1 for one cycle after E5, `busy`=1 for 3 cycles, `r`=0 throughout, no second strobe while held.
3. `clr_req` high for 3 cycles then low, repeated 5 times → `r` never asserts and `busy` stays 0.
4. `set_req` and `clr_req` rise on the same edge and are held → `conflict`=1 for one cycle after E5, `s`=`r`=0 throughout, `busy`=0.
5. `set_req` rises at E1; `clr_req` rises at E3 (its `f` rises during `HOLD`) → `s` strobe after E5, then `r` strobe exactly 4 cycles after `s` (spacing `HOLD_CYCLES`+2), never overlapping.
6. `set_req` held; `rst` pulsed for 1 cycle during `HOLD` → all outputs 0 at once; after release, a fresh `s` strobe occurs 5 edges after the first post-reset sampling edge.
